vc_writeback_buffer: RTL



---
 rtl/vc_wbb_pkg.sv | 18 +
 rtl/vc_wbb_match.sv | 34 +++
 rtl/vc_wbb_writeback_buffer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/vc_wbb_pkg.sv
// Shared sizing for the victim-cache writeback buffer: L1.5 geometry aliases
// and the pointer-width helper used by the queue and the age matcher.
package vc_wbb_pkg;

    localparam int L15_CACHE_TAG_WIDTH   = 28;
    localparam int L15_CACHE_INDEX_WIDTH = 8;
    localparam int L15_CACHELINE_WIDTH   = 128;

    localparam int WBB_DEPTH      = 4;
    localparam int WBB_ADDR_WIDTH = L15_CACHE_TAG_WIDTH + L15_CACHE_INDEX_WIDTH;
    localparam int WBB_DATA_WIDTH = L15_CACHELINE_WIDTH;

    // Pointer width; kept at least one bit so a single-entry queue still elaborates.
    function automatic int wbb_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/vc_wbb_match.sv
// Age-priority address matcher: walks entries oldest (head) to youngest and
// reports the youngest valid entry whose address equals the lookup address.
module vc_wbb_match
    import vc_wbb_pkg::*;
#(
    parameter int DEPTH      = WBB_DEPTH,
    parameter int ADDR_WIDTH = WBB_ADDR_WIDTH,
    parameter int PTR_W      = wbb_ptr_width(DEPTH)
) (
    input  logic [DEPTH-1:0]      valid_i,
    input  logic [ADDR_WIDTH-1:0] addr_i [DEPTH],
    input  logic [PTR_W-1:0]      head_i,
    input  logic [ADDR_WIDTH-1:0] lkup_addr_i,
    output logic                  hit_o,
    output logic [PTR_W-1:0]      idx_o
);

    logic [PTR_W-1:0] slot;

    // Later (younger) matches overwrite earlier ones, so the last hit wins.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        slot  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_i + PTR_W'(k);
            if (valid_i[slot] && (addr_i[slot] == lkup_addr_i)) begin
                hit_o = 1'b1;
                idx_o = slot;
            end
        end
    end

endmodule

// File: rtl/vc_wbb_writeback_buffer.sv
// In-order writeback queue for dirty victims, drained to NoC1 with val/ack,
// plus an S1->S2 lookup that forwards data from the youngest pending copy.
module vc_writeback_buffer
    import vc_wbb_pkg::*;
#(
    parameter int DEPTH      = WBB_DEPTH,
    parameter int ADDR_WIDTH = WBB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WBB_DATA_WIDTH,
    localparam int PTR_W     = wbb_ptr_width(DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vc_wbb_enq_val_s3,
    input  logic [ADDR_WIDTH-1:0] vc_wbb_enq_addr_s3,
    input  logic [DATA_WIDTH-1:0] vc_wbb_enq_data_s3,
    output logic                  wbb_vc_full,
    input  logic                  l15_wbb_lkup_val_s1,
    input  logic [ADDR_WIDTH-1:0] l15_wbb_lkup_addr_s1,
    output logic                  wbb_l15_hit_s2,
    output logic [DATA_WIDTH-1:0] wbb_l15_data_s2,
    output logic                  wbb_noc_val,
    output logic [ADDR_WIDTH-1:0] wbb_noc_addr,
    output logic [DATA_WIDTH-1:0] wbb_noc_data,
    input  logic                  noc_wbb_ack,
    output logic [CNT_W-1:0]      wbb_count,
    output logic                  wbb_overflow
);

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic                  overflow_q, overflow_d;
    logic                  hit_s2_q, hit_s2_d;
    logic [DATA_WIDTH-1:0] data_s2_q, data_s2_d;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] line_q [DEPTH];

    logic                  full;
    logic                  pop;
    logic                  accept;
    logic                  lk_hit;
    logic [PTR_W-1:0]      lk_idx;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign pop    = wbb_noc_val & noc_wbb_ack;
    // A full queue still takes a line when the head leaves in the same cycle.
    assign accept = vc_wbb_enq_val_s3 & (~full | pop);

    vc_wbb_match #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PTR_W      (PTR_W)
    ) u_match (
        .valid_i     (valid_q),
        .addr_i      (addr_q),
        .head_i      (head_q),
        .lkup_addr_i (l15_wbb_lkup_addr_s1),
        .hit_o       (lk_hit),
        .idx_o       (lk_idx)
    );

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        // Clear before set: when full, head and tail alias and the new line must survive.
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (accept) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (vc_wbb_enq_val_s3 && !accept) begin
            overflow_d = 1'b1;
        end
        count_d   = count_q + CNT_W'(accept) - CNT_W'(pop);
        hit_s2_d  = l15_wbb_lkup_val_s1 & lk_hit;
        data_s2_d = hit_s2_d ? line_q[lk_idx] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            overflow_q <= 1'b0;
            hit_s2_q   <= 1'b0;
            data_s2_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            hit_s2_q   <= hit_s2_d;
            data_s2_q  <= data_s2_d;
        end
    end

    // Payload storage needs no reset; every consumer is qualified by a valid bit.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q[tail_q] <= vc_wbb_enq_addr_s3;
            line_q[tail_q] <= vc_wbb_enq_data_s3;
        end
    end

    assign wbb_vc_full     = full;
    assign wbb_noc_val     = (count_q != '0);
    assign wbb_noc_addr    = wbb_noc_val ? addr_q[head_q] : '0;
    assign wbb_noc_data    = wbb_noc_val ? line_q[head_q] : '0;
    assign wbb_count       = count_q;
    assign wbb_overflow    = overflow_q;
    assign wbb_l15_hit_s2  = hit_s2_q;
    assign wbb_l15_data_s2 = data_s2_q;

endmodule
